// File: rtl/ex_mem_skid.sv
// rtl/ex_mem_skid.sv - execute-to-memory elastic pipeline register with 2-entry skid buffer
module ex_mem_skid #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  // execute-stage side
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic              ex_zf,
  input  logic              ex_cf,
  input  logic              ex_sf,
  input  logic              ex_of,
  input  logic              ex_err,
  input  logic [DATA_W-1:0] ex_st_data,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_reg_wr,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic              ex_halt,
  // memory-stage side
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_alu_out,
  output logic [DATA_W-1:0] mem_st_data,
  output logic              mem_zf,
  output logic              mem_cf,
  output logic              mem_sf,
  output logic              mem_of,
  output logic              mem_reg_wr,
  output logic              mem_mem_rd,
  output logic              mem_mem_wr,
  output logic              mem_halt,
  output logic [RD_W-1:0]   mem_rd,
  // control / status
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic              err_sticky
);

  // One pipeline entry. The ALU error bit is not carried forward; it only
  // feeds the sticky error flag at accept time.
  typedef struct packed {
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] st_data;
    logic [RD_W-1:0]   rd;
    logic              zf;
    logic              cf;
    logic              sf;
    logic              of;
    logic              reg_wr;
    logic              mem_rd;
    logic              mem_wr;
    logic              halt;
  } entry_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  entry_t in_entry;
  entry_t head_q;
  entry_t skid_q;

  logic halt_pend_q;
  logic err_q;

  logic accept;
  logic retire;
  logic load_h_in;
  logic load_h_skid;
  logic load_s;

  // Pack the incoming execute-stage fields into one entry.
  always_comb begin
    in_entry         = '0;
    in_entry.alu_out = ex_alu_out;
    in_entry.st_data = ex_st_data;
    in_entry.rd      = ex_rd;
    in_entry.zf      = ex_zf;
    in_entry.cf      = ex_cf;
    in_entry.sf      = ex_sf;
    in_entry.of      = ex_of;
    in_entry.reg_wr  = ex_reg_wr;
    in_entry.mem_rd  = ex_mem_rd;
    in_entry.mem_wr  = ex_mem_wr;
    in_entry.halt    = ex_halt;
  end

  // Ready comes only from registered state and flush, never from mem_ready,
  // so the stall path from the memory stage is cut at this register.
  assign ex_ready  = (state_q != ST_FULL) & ~halt_pend_q & ~flush;
  assign mem_valid = (state_q != ST_EMPTY);
  assign accept    = ex_valid & ex_ready;
  assign retire    = mem_valid & mem_ready;
  assign occupancy = state_q;

  // Next-state and storage-load decode for the EMPTY/ONE/FULL skid FSM.
  always_comb begin
    state_d     = state_q;
    load_h_in   = 1'b0;
    load_h_skid = 1'b0;
    load_s      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d   = ST_ONE;
          load_h_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && retire) begin
          load_h_in = 1'b1;
        end else if (accept) begin
          state_d = ST_FULL;
          load_s  = 1'b1;
        end else if (retire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // ex_ready is low here, so only a retire can move the FSM.
        if (retire) begin
          state_d     = ST_ONE;
          load_h_skid = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    // Flush wins over everything; a retire in the same cycle still completes
    // downstream, the entry is just not kept.
    if (flush) begin
      state_d     = ST_EMPTY;
      load_h_in   = 1'b0;
      load_h_skid = 1'b0;
      load_s      = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Head register: loaded from the input or promoted from the skid slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
    end else if (load_h_in) begin
      head_q <= in_entry;
    end else if (load_h_skid) begin
      head_q <= skid_q;
    end
  end

  // Skid register: catches the entry that arrives while the head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= '0;
    end else if (load_s) begin
      skid_q <= in_entry;
    end
  end

  // Halt pending: once a halt is accepted, stop taking work until flush/reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_pend_q <= 1'b0;
    end else if (flush) begin
      halt_pend_q <= 1'b0;
    end else if (accept && ex_halt) begin
      halt_pend_q <= 1'b1;
    end
  end

  // Sticky error: remembers any accepted ALU error until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept && ex_err) begin
      err_q <= 1'b1;
    end
  end

  assign err_sticky = err_q;

  // Head entry drives the memory stage directly.
  assign mem_alu_out = head_q.alu_out;
  assign mem_st_data = head_q.st_data;
  assign mem_rd      = head_q.rd;
  assign mem_zf      = head_q.zf;
  assign mem_cf      = head_q.cf;
  assign mem_sf      = head_q.sf;
  assign mem_of      = head_q.of;
  assign mem_reg_wr  = head_q.reg_wr;
  assign mem_mem_rd  = head_q.mem_rd;
  assign mem_mem_wr  = head_q.mem_wr;
  assign mem_halt    = head_q.halt;

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb/tb_ex_mem_skid.sv - directed self-checking bench for ex_mem_skid
module tb_ex_mem_skid;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [15:0] ex_alu_out;
  logic        ex_zf, ex_cf, ex_sf, ex_of, ex_err;
  logic [15:0] ex_st_data;
  logic [2:0]  ex_rd;
  logic        ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_halt;
  logic        mem_valid;
  logic        mem_ready;
  logic [15:0] mem_alu_out, mem_st_data;
  logic        mem_zf, mem_cf, mem_sf, mem_of;
  logic        mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_halt;
  logic [2:0]  mem_rd;
  logic        flush;
  logic [1:0]  occupancy;
  logic        err_sticky;

  int n_checks = 0;
  int n_fails  = 0;

  ex_mem_skid #(.DATA_W(16), .RD_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_out(ex_alu_out),
    .ex_zf(ex_zf), .ex_cf(ex_cf), .ex_sf(ex_sf), .ex_of(ex_of), .ex_err(ex_err),
    .ex_st_data(ex_st_data), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_halt(ex_halt),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_alu_out(mem_alu_out), .mem_st_data(mem_st_data),
    .mem_zf(mem_zf), .mem_cf(mem_cf), .mem_sf(mem_sf), .mem_of(mem_of),
    .mem_reg_wr(mem_reg_wr), .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr),
    .mem_halt(mem_halt), .mem_rd(mem_rd),
    .flush(flush), .occupancy(occupancy), .err_sticky(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid = 0; ex_alu_out = '0; ex_zf = 0; ex_cf = 0; ex_sf = 0; ex_of = 0;
    ex_err = 0; ex_st_data = '0; ex_rd = '0; ex_reg_wr = 0; ex_mem_rd = 0;
    ex_mem_wr = 0; ex_halt = 0; mem_ready = 0; flush = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    step();
    step();
    n_checks++; if (mem_valid !== 1'b0) begin n_fails++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
    n_checks++; if (occupancy !== 2'd0) begin n_fails++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    n_checks++; if (mem_alu_out !== 16'h0000) begin n_fails++; $display("FAIL reset_alu_out got=%h exp=0000", mem_alu_out); end
    n_checks++; if (err_sticky !== 1'b0) begin n_fails++; $display("FAIL reset_err_sticky got=%b exp=0", err_sticky); end
    n_checks++; if (ex_ready !== 1'b1) begin n_fails++; $display("FAIL reset_ex_ready got=%b exp=1", ex_ready); end
    rst_n = 1;
    step();
  endtask

  task automatic test_passthrough();
    mem_ready = 1;
    ex_valid = 1; ex_alu_out = 16'h1234; ex_zf = 0; ex_sf = 1; ex_cf = 1; ex_of = 0;
    ex_st_data = 16'hBEEF; ex_rd = 3'd2; ex_reg_wr = 1; ex_mem_wr = 1;
    #1;
    n_checks++; if (mem_valid !== 1'b0) begin n_fails++; $display("FAIL pass_latency got=%b exp=0", mem_valid); end
    step();
    n_checks++; if (mem_valid !== 1'b1) begin n_fails++; $display("FAIL pass_mem_valid got=%b exp=1", mem_valid); end
    n_checks++; if (mem_alu_out !== 16'h1234) begin n_fails++; $display("FAIL pass_alu_out got=%h exp=1234", mem_alu_out); end
    n_checks++; if (mem_st_data !== 16'hBEEF) begin n_fails++; $display("FAIL pass_st_data got=%h exp=beef", mem_st_data); end
    n_checks++; if ({mem_zf, mem_cf, mem_sf, mem_of} !== 4'b0110) begin n_fails++; $display("FAIL pass_flags got=%b exp=0110", {mem_zf, mem_cf, mem_sf, mem_of}); end
    n_checks++; if ({mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_halt} !== 4'b1010) begin n_fails++; $display("FAIL pass_ctrl got=%b exp=1010", {mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_halt}); end
    n_checks++; if (mem_rd !== 3'd2) begin n_fails++; $display("FAIL pass_rd got=%0d exp=2", mem_rd); end
    n_checks++; if (occupancy !== 2'd1) begin n_fails++; $display("FAIL pass_occupancy got=%0d exp=1", occupancy); end
    clear_inputs();
    mem_ready = 1;
    ex_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      ex_alu_out = 16'(i);
      step();
      n_checks++; if (mem_alu_out !== 16'(i)) begin n_fails++; $display("FAIL b2b_order[%0d] got=%h exp=%h", i, mem_alu_out, 16'(i)); end
      n_checks++; if (occupancy !== 2'd1) begin n_fails++; $display("FAIL b2b_occupancy[%0d] got=%0d exp=1", i, occupancy); end
    end
    ex_valid = 0;
    step();
    n_checks++; if (occupancy !== 2'd0 || mem_valid !== 1'b0) begin n_fails++; $display("FAIL b2b_drain got occ=%0d valid=%b exp occ=0 valid=0", occupancy, mem_valid); end
    clear_inputs();
  endtask

  task automatic test_stall();
    mem_ready = 0;
    ex_valid = 1; ex_alu_out = 16'hAAAA;
    step();
    n_checks++; if (occupancy !== 2'd1) begin n_fails++; $display("FAIL stall_occ1 got=%0d exp=1", occupancy); end
    ex_alu_out = 16'hBBBB;
    step();
    n_checks++; if (occupancy !== 2'd2) begin n_fails++; $display("FAIL stall_occ2 got=%0d exp=2", occupancy); end
    n_checks++; if (ex_ready !== 1'b0) begin n_fails++; $display("FAIL stall_ready_full got=%b exp=0", ex_ready); end
    n_checks++; if (mem_alu_out !== 16'hAAAA) begin n_fails++; $display("FAIL stall_head got=%h exp=aaaa", mem_alu_out); end
    ex_alu_out = 16'hCCCC;
    step();
    n_checks++; if (mem_alu_out !== 16'hAAAA || occupancy !== 2'd2) begin n_fails++; $display("FAIL stall_hold got=%h occ=%0d exp=aaaa occ=2", mem_alu_out, occupancy); end
    ex_valid = 0;
    mem_ready = 1;
    step();
    n_checks++; if (mem_alu_out !== 16'hBBBB || occupancy !== 2'd1) begin n_fails++; $display("FAIL stall_retire_a got=%h occ=%0d exp=bbbb occ=1", mem_alu_out, occupancy); end
    step();
    n_checks++; if (occupancy !== 2'd0 || mem_valid !== 1'b0) begin n_fails++; $display("FAIL stall_retire_b got occ=%0d valid=%b exp occ=0 valid=0", occupancy, mem_valid); end
    clear_inputs();
  endtask

  task automatic test_flush();
    ex_valid = 1; ex_alu_out = 16'h1111;
    step();
    ex_alu_out = 16'h2222;
    step();
    n_checks++; if (occupancy !== 2'd2) begin n_fails++; $display("FAIL flush_fill got=%0d exp=2", occupancy); end
    ex_valid = 0;
    flush = 1;
    #1;
    n_checks++; if (ex_ready !== 1'b0) begin n_fails++; $display("FAIL flush_ready_during got=%b exp=0", ex_ready); end
    step();
    n_checks++; if (occupancy !== 2'd0 || mem_valid !== 1'b0) begin n_fails++; $display("FAIL flush_empty got occ=%0d valid=%b exp occ=0 valid=0", occupancy, mem_valid); end
    flush = 0;
    #1;
    n_checks++; if (ex_ready !== 1'b1) begin n_fails++; $display("FAIL flush_ready_after got=%b exp=1", ex_ready); end
    step();
    clear_inputs();
  endtask

  task automatic test_halt();
    ex_valid = 1; ex_halt = 1; ex_rd = 3'd5; ex_alu_out = 16'h0055;
    step();
    n_checks++; if (mem_halt !== 1'b1 || mem_rd !== 3'd5) begin n_fails++; $display("FAIL halt_head got halt=%b rd=%0d exp halt=1 rd=5", mem_halt, mem_rd); end
    n_checks++; if (ex_ready !== 1'b0) begin n_fails++; $display("FAIL halt_ready_pend got=%b exp=0", ex_ready); end
    ex_valid = 0; ex_halt = 0; ex_rd = 3'd0;
    mem_ready = 1;
    step();
    n_checks++; if (occupancy !== 2'd0) begin n_fails++; $display("FAIL halt_retired got=%0d exp=0", occupancy); end
    ex_valid = 1; ex_alu_out = 16'h0077;
    step();
    n_checks++; if (ex_ready !== 1'b0 || occupancy !== 2'd0) begin n_fails++; $display("FAIL halt_blocks got ready=%b occ=%0d exp ready=0 occ=0", ex_ready, occupancy); end
    ex_valid = 0;
    flush = 1;
    step();
    flush = 0;
    #1;
    n_checks++; if (ex_ready !== 1'b1) begin n_fails++; $display("FAIL halt_flush_ready got=%b exp=1", ex_ready); end
    step();
    clear_inputs();
  endtask

  task automatic test_error();
    mem_ready = 1;
    ex_valid = 1; ex_err = 1; ex_alu_out = 16'hE000;
    step();
    n_checks++; if (err_sticky !== 1'b1) begin n_fails++; $display("FAIL err_set got=%b exp=1", err_sticky); end
    ex_err = 0;
    for (int i = 0; i < 10; i++) begin
      ex_alu_out = 16'(i);
      step();
      n_checks++; if (err_sticky !== 1'b1) begin n_fails++; $display("FAIL err_hold[%0d] got=%b exp=1", i, err_sticky); end
    end
    ex_valid = 0;
    flush = 1;
    step();
    flush = 0;
    step();
    n_checks++; if (err_sticky !== 1'b1) begin n_fails++; $display("FAIL err_after_flush got=%b exp=1", err_sticky); end
    rst_n = 0;
    #2;
    n_checks++; if (err_sticky !== 1'b0) begin n_fails++; $display("FAIL err_reset got=%b exp=0", err_sticky); end
    rst_n = 1;
    step();
    clear_inputs();
  endtask

  task automatic test_async_reset();
    mem_ready = 0;
    ex_valid = 1; ex_alu_out = 16'hAAAA; ex_halt = 0;
    step();
    ex_alu_out = 16'hBBBB; ex_sf = 1;
    step();
    ex_valid = 0;
    n_checks++; if (occupancy !== 2'd2 || mem_alu_out !== 16'hAAAA) begin n_fails++; $display("FAIL areset_fill got occ=%0d alu=%h exp occ=2 alu=aaaa", occupancy, mem_alu_out); end
    #3;
    rst_n = 0;
    #1;
    n_checks++; if (mem_valid !== 1'b0) begin n_fails++; $display("FAIL areset_mem_valid got=%b exp=0", mem_valid); end
    n_checks++; if (occupancy !== 2'd0) begin n_fails++; $display("FAIL areset_occupancy got=%0d exp=0", occupancy); end
    n_checks++; if (mem_alu_out !== 16'h0000) begin n_fails++; $display("FAIL areset_alu_out got=%h exp=0000", mem_alu_out); end
    #1;
    rst_n = 1;
    step();
    n_checks++; if (mem_valid !== 1'b0 || ex_ready !== 1'b1) begin n_fails++; $display("FAIL areset_after got valid=%b ready=%b exp valid=0 ready=1", mem_valid, ex_ready); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_stall();
    test_flush();
    test_halt();
    test_error();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
